// File: rtl/cwe1234_pkg.sv
// Shared definitions for the debug-unlock controller: FSM state encoding,
// default parameter values and the timer-width helper.
package cwe1234_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHECK    = 2'd1,
      UNLOCKED = 2'd2,
      LOCKOUT  = 2'd3
   } dbg_state_t;

   localparam int DEF_KEY_W          = 16;
   localparam int DEF_MAX_ATTEMPTS   = 3;
   localparam int DEF_LOCKOUT_CYCLES = 256;
   localparam int DEF_SESSION_CYCLES = 1024;

   // The shared timer must hold the longer of the two load values (N-1).
   // A one-cycle phase still needs a one-bit counter.
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/cwe1234_debug_unlock_ctrl_if.sv
// Key-presentation handshake between the debug agent (master) and the
// unlock controller (slave).
interface cwe1234_debug_unlock_ctrl_if
   import cwe1234_pkg::*;
#(
   parameter int KEY_W = DEF_KEY_W
);

   logic [KEY_W-1:0] key_in;
   logic             key_valid;
   logic             key_ready;

   // Debug agent: presents a key and holds it until accepted.
   modport master (
      output key_in,
      output key_valid,
      input  key_ready
   );

   // Controller: accepts a key only while idle.
   modport slave (
      input  key_in,
      input  key_valid,
      output key_ready
   );

endinterface

// File: rtl/cwe1234_down_timer.sv
// Loadable down-counter shared by the unlock-session and lockout phases.
// It parks at zero rather than wrapping, so a stray enable cannot restart it.
module cwe1234_down_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   // Load has priority over counting; decrement stops at zero.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement or process order.
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !zero) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/cwe1234_debug_unlock_ctrl.sv
// Debug-unlock authentication controller. Accepts a candidate key, compares
// it against the fused secret, opens a time-limited unlock session on a
// match and forces a timed lockout after repeated mismatches. Also keeps the
// sticky Lock status consumed by the lock-protected registers downstream.
module cwe1234_debug_unlock_ctrl
   import cwe1234_pkg::*;
#(
   parameter int KEY_W          = DEF_KEY_W,
   parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
   parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
   parameter int SESSION_CYCLES = DEF_SESSION_CYCLES
) (
   input  logic                        Clk,
   input  logic                        reset,
   cwe1234_debug_unlock_ctrl_if.slave  key_bus,
   input  logic [KEY_W-1:0]            secret_key,
   input  logic                        Lock_req,
   input  logic                        relock,
   output logic                        Lock,
   output logic                        debug_unlocked,
   output logic                        attempt_fail,
   output logic                        locked_out
);

   localparam int CNT_W = $clog2(MAX_ATTEMPTS + 1);
   localparam int TMR_W = timer_width(SESSION_CYCLES, LOCKOUT_CYCLES);

   localparam logic [CNT_W-1:0] MAX_CNT      = CNT_W'(MAX_ATTEMPTS);
   localparam logic [TMR_W-1:0] SESSION_LOAD = TMR_W'(SESSION_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

   dbg_state_t       state_q;
   dbg_state_t       state_d;
   logic [CNT_W-1:0] fail_cnt_q;
   logic [CNT_W-1:0] fail_cnt_d;
   logic [KEY_W-1:0] key_q;
   logic             attempt_fail_d;
   logic             handshake;
   logic             key_match;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_load_val;
   logic             tmr_en;
   logic             tmr_zero;

   // Keys are taken only in IDLE; anything presented elsewhere stays with
   // the agent until the controller returns to IDLE.
   assign key_bus.key_ready = (state_q == IDLE);
   assign handshake         = key_bus.key_valid && key_bus.key_ready;

   // An all-zero secret means debug is fused off, so nothing can match it.
   assign key_match = (key_q == secret_key) && (secret_key != '0);

   cwe1234_down_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk      (Clk),
      .rst      (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   // Next-state, fail-count and timer-control decode.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d        = state_q;
      fail_cnt_d     = fail_cnt_q;
      attempt_fail_d = 1'b0;
      tmr_load       = 1'b0;
      tmr_load_val   = '0;
      tmr_en         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (handshake) begin
               state_d = CHECK;
            end
         end

         CHECK: begin
            if (key_match) begin
               state_d      = UNLOCKED;
               fail_cnt_d   = '0;
               tmr_load     = 1'b1;
               tmr_load_val = SESSION_LOAD;
            end else begin
               attempt_fail_d = 1'b1;
               if (fail_cnt_q != MAX_CNT) begin
                  fail_cnt_d = fail_cnt_q + 1'b1;
               end
               if (fail_cnt_d == MAX_CNT) begin
                  state_d      = LOCKOUT;
                  tmr_load     = 1'b1;
                  tmr_load_val = LOCKOUT_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         UNLOCKED: begin
            tmr_en = 1'b1;
            // relock ends the session even if time remains.
            if (relock || tmr_zero) begin
               state_d = IDLE;
            end
         end

         LOCKOUT: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               state_d    = IDLE;
               fail_cnt_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state, fail counter and captured key.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         fail_cnt_q <= '0;
         key_q      <= '0;
      end else begin
         state_q    <= state_d;
         fail_cnt_q <= fail_cnt_d;
         if (handshake) begin
            key_q <= key_bus.key_in;
         end
      end
   end

   // Registered status outputs, aligned with the state they describe.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         debug_unlocked <= 1'b0;
         locked_out     <= 1'b0;
         attempt_fail   <= 1'b0;
      end else begin
         debug_unlocked <= (state_d == UNLOCKED);
         locked_out     <= (state_d == LOCKOUT);
         attempt_fail   <= attempt_fail_d;
      end
   end

   // Sticky lock: set by request in any state, cleared only by reset.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         Lock <= 1'b0;
      end else if (Lock_req) begin
         Lock <= 1'b1;
      end
   end

   // Structural invariants of the controller.
   a_unlock_tracks_state : assert property (@(posedge Clk) disable iff (reset)
      debug_unlocked == (state_q == UNLOCKED));
   a_lockout_tracks_state : assert property (@(posedge Clk) disable iff (reset)
      locked_out == (state_q == LOCKOUT));
   a_fail_is_pulse : assert property (@(posedge Clk) disable iff (reset)
      attempt_fail |=> !attempt_fail);
   a_fail_cnt_bounded : assert property (@(posedge Clk) disable iff (reset)
      fail_cnt_q <= MAX_CNT);

endmodule
